inv_subbytes_seq: RTL and testbench

INV_SUBBYTES_SEQ -- requirements
Module: inv_subbytes_seq

---
 rtl/aes_ctrl_pkg.sv | 31 +++
 rtl/inv_sbox_rom.sv | 32 +++
 rtl/inv_subbytes_seq.sv | 108 ++++++++++
 tb/tb_inv_subbytes_seq.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared FSM state type, geometry/latency constants and byte-slot helper for the
// sequential inverse SubBytes engine. INV_SUBBYTES_DUAL_LANE_EN selects two ROM lanes.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BYTES_PER_STATE = 16;
    localparam int LATENCY_SINGLE  = 17;
    localparam int LATENCY_DUAL    = 9;

`ifdef INV_SUBBYTES_DUAL_LANE_EN
    localparam int LANES = 2;
`else
    localparam int LANES = 1;
`endif

    localparam int ISSUES = BYTES_PER_STATE / LANES;

    // Bit offset of byte idx inside the 128-bit state; byte 0 is the top byte when first_msb.
    function automatic logic [6:0] byte_lsb(input logic [3:0] idx, input logic first_msb);
        logic [3:0] pos;
        pos = first_msb ? ~idx : idx;
        return {pos, 3'b000};
    endfunction

endpackage

// File: rtl/inv_sbox_rom.sv
// AES inverse S-box lookup with a registered output (one cycle from addr to q).
module inv_sbox_rom (
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] q
);

    // Entry 0 sits at the left of the concatenation.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    always_ff @(posedge clk) begin
        q <= INV_SBOX[addr];
    end

endmodule

// File: rtl/inv_subbytes_seq.sv
// Sequential InvSubBytes over a 128-bit state: bytes stream through registered ROM lane(s).
// Define INV_SUBBYTES_DUAL_LANE_EN for two lanes (9-edge latency instead of 17).
module inv_subbytes_seq #(
    parameter int FIRST_BYTE_MSB = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    import aes_ctrl_pkg::*;

    localparam logic [3:0] LAST_CNT  = 4'(ISSUES - 1);
    localparam logic       FIRST_MSB = (FIRST_BYTE_MSB != 0);

    state_t                  state_reg, state_next;
    logic [127:0]            data_reg;
    logic [127:0]            result_reg;
    logic [3:0]              cnt_reg;
    logic                    wr_valid_reg;
    logic [LANES-1:0][3:0]   wr_idx_reg;
    logic [LANES-1:0][3:0]   issue_idx;
    logic [LANES-1:0][7:0]   rom_addr;
    logic [LANES-1:0][7:0]   rom_q;
    logic                    accept;

    assign accept = (state_reg == IDLE) && in_valid && !flush;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign issue_idx[gi] = 4'(cnt_reg * LANES + gi);
            assign rom_addr[gi]  = data_reg[byte_lsb(issue_idx[gi], FIRST_MSB) +: 8];

            inv_sbox_rom u_rom (
                .clk  (clk),
                .addr (rom_addr[gi]),
                .q    (rom_q[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (cnt_reg == LAST_CNT) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        busy      = (state_reg != IDLE);
        out_valid = (state_reg == DONE);
    end

    // ROM results land in the result register one edge after the ROM registers them,
    // so the issue index travels alongside in wr_idx_reg.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg     <= '0;
            result_reg   <= '0;
            cnt_reg      <= '0;
            wr_valid_reg <= 1'b0;
            wr_idx_reg   <= '0;
        end else if (flush) begin
            cnt_reg      <= '0;
            wr_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                data_reg <= in_data;
                cnt_reg  <= '0;
            end else if (state_reg == RUN && cnt_reg != LAST_CNT) begin
                cnt_reg <= cnt_reg + 4'd1;
            end
            wr_valid_reg <= (state_reg == RUN);
            wr_idx_reg   <= issue_idx;
            if (wr_valid_reg) begin
                for (int li = 0; li < LANES; li++) begin
                    result_reg[byte_lsb(wr_idx_reg[li], FIRST_MSB) +: 8] <= rom_q[li];
                end
            end
        end
    end

    assign out_data = result_reg;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Directed bench for inv_subbytes_seq: latency, data, stall, flush, reset and back-to-back jobs.
module tb_inv_subbytes_seq;

`ifdef INV_SUBBYTES_DUAL_LANE_EN
    localparam int EXP_LAT = 9;
`else
    localparam int EXP_LAT = 17;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;

    int total = 0;
    int bad = 0;

    inv_subbytes_seq #(.FIRST_BYTE_MSB(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Offer d at the next edge (E0); returns 1 time unit after E0.
    task automatic accept(input logic [127:0] d, input bit keep);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    // Counts edges after E0 until out_valid is seen, bounded at 60.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic transfer();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (out_data !== 128'h0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: out_data=%h out_valid=%b busy=%b want 0/0/0", out_data, out_valid, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_zero();
        int e;
        accept(128'h0, 1'b0);
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL zero_busy: busy=%b in_ready=%b want 1/0", busy, in_ready);
        end
        wait_valid(e);
        total++;
        if (e !== EXP_LAT) begin
            bad++;
            $display("FAIL zero_latency: got %0d want %0d", e, EXP_LAT);
        end
        total++;
        if (out_data !== {16{8'h52}}) begin
            bad++;
            $display("FAIL zero_data: got %h want %h", out_data, {16{8'h52}});
        end
        transfer();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL zero_transfer: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        $display("test_zero: latency=%0d out=%h", e, out_data);
    endtask

    task automatic test_sequence();
        int e;
        accept(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
        wait_valid(e);
        total++;
        if (e !== EXP_LAT) begin
            bad++;
            $display("FAIL seq_latency: got %0d want %0d", e, EXP_LAT);
        end
        total++;
        if (out_data !== 128'h52096ad53036a538bf40a39e81f3d7fb) begin
            bad++;
            $display("FAIL seq_data: got %h want 52096ad53036a538bf40a39e81f3d7fb", out_data);
        end
        transfer();
        $display("test_sequence: out=%h", out_data);
    endtask

    task automatic test_stall();
        int e;
        logic [127:0] exp_d;
        exp_d = {8{8'h00, 8'h01}};
        accept({8{8'h63, 8'h7c}}, 1'b0);
        wait_valid(e);
        total++;
        if (out_data !== exp_d) begin
            bad++;
            $display("FAIL stall_data: got %h want %h", out_data, exp_d);
        end
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_d || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cycle %0d: out_valid=%b in_ready=%b out=%h want 1/0 %h",
                         i, out_valid, in_ready, out_data, exp_d);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: out_valid=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b0;
        $display("test_stall: held 50 cycles, released");
    endtask

    task automatic test_flush();
        int e;
        int seen;
        accept(128'h0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle: in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        end
        @(negedge clk);
        flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL flush_no_valid: out_valid seen %0d cycles want 0", seen);
        end
        accept({16{8'hff}}, 1'b0);
        wait_valid(e);
        total++;
        if (e !== EXP_LAT || out_data !== {16{8'h7d}}) begin
            bad++;
            $display("FAIL flush_next_job: latency=%0d out=%h want %0d %h", e, out_data, EXP_LAT, {16{8'h7d}});
        end
        transfer();
        $display("test_flush: next job out=%h", out_data);
    endtask

    task automatic test_flush_priority();
        int e;
        accept(128'h0, 1'b0);
        wait_valid(e);
        @(negedge clk);
        out_ready = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_over_handshake: out_valid=%b busy=%b want 0/0", out_valid, busy);
        end
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_over_accept: busy=%b want 0", busy);
        end
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        $display("test_flush_priority done");
    endtask

    task automatic test_reset_mid_run();
        int e;
        accept(128'h0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (out_data !== 128'h0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_run: out=%h out_valid=%b busy=%b in_ready=%b want 0/0/0/1",
                     out_data, out_valid, busy, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        accept({16{8'h7c}}, 1'b0);
        wait_valid(e);
        total++;
        if (e !== EXP_LAT || out_data !== {16{8'h01}}) begin
            bad++;
            $display("FAIL reset_next_job: latency=%0d out=%h want %0d %h", e, out_data, EXP_LAT, {16{8'h01}});
        end
        transfer();
        $display("test_reset_mid_run: next job out=%h", out_data);
    endtask

    task automatic test_back_to_back();
        int e;
        out_ready = 1'b1;
        accept({16{8'h63}}, 1'b1);
        e = 0;
        while (out_valid !== 1'b1 && e < 60) begin
            @(negedge clk);
            in_data = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            e++;
        end
        total++;
        if (e !== EXP_LAT || out_data !== 128'h0) begin
            bad++;
            $display("FAIL b2b_first: latency=%0d out=%h want %0d 0", e, out_data, EXP_LAT);
        end
        @(negedge clk);
        in_data = {16{8'h7c}};
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_accept: busy=%b want 1", busy);
        end
        wait_valid(e);
        total++;
        if (e !== EXP_LAT || out_data !== {16{8'h01}}) begin
            bad++;
            $display("FAIL b2b_second: latency=%0d out=%h want %0d %h", e, out_data, EXP_LAT, {16{8'h01}});
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        out_ready = 1'b0;
        $display("test_back_to_back: second out=%h", out_data);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_sequence();
        test_stall();
        test_flush();
        test_flush_priority();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
